decode_stage_hz: RTL and testbench
==================================

# decode_stage_hz

Parametrised ID/EX stage with hazard handling, sitting between the fetch/decode register and the execute stage of the pipelined RISC-V core. It decodes `InstrD` with the existing `Control_Unit_Top` and `Sign_Extend` blocks and reads an internal write-through register file. It detects load-use hazards and registers everything into the E stage with stall, flush and bubble control, plus a saturating bubble counter.

## Interface
- `XLEN`, 32, datapath width (PC, register data, immediate)
- `NREGS`, 32, architectural register count; `AW = $clog2(NREGS)` sets register index width
- `CNT_W`, 16, bubble counter width
- `clk` in 1: clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `ValidD` in 1: `InstrD` holds a real instruction
- `InstrD` in 32: instruction in decode
- `PCD`, `PCPlus4D` in XLEN: PC and PC+4 of `InstrD`
- `StallE` in 1: hold the E register (downstream busy)
- `FlushE` in 1: load a bubble into E (branch taken)
- `RegWriteW` in 1, `RDW` in AW, `ResultW` in XLEN: writeback port
- `HazardStall` out 1: load-use detected; upstream must hold F and D this cycle
- `ValidE`, `RegWriteE`, `ALUSrcE`, `MemWriteE`, `ResultSrcE`, `BranchE` out 1 each: registered control
- `ALUControlE` out 3: registered ALU control
- `RD1_E`, `RD2_E`, `Imm_Ext_E`, `PCE`, `PCPlus4E` out XLEN each: registered data
- `RS1_E`, `RS2_E`, `RD_E` out AW each: registered register indices
- `BubbleCount` out CNT_W: number of bubbles inserted into E, saturating

## Operation
- Register file: NREGS×XLEN. Entry 0 always reads 0.
  - Writes on rising `clk` when `RegWriteW` is 1 and `RDW` is not 0.
  - Reads are combinational with write-through: if `RegWriteW` is 1, `RDW == rs` and `rs` is not 0, the read returns `ResultW`.
  - Async reset clears every entry to 0.
- Index fields: rs1D = `InstrD[15+:AW]`, rs2D = `InstrD[20+:AW]`, rdD = `InstrD[7+:AW]`. For NREGS < 32, the upper index bits are ignored.
- Immediate: the 32-bit `Sign_Extend` result, sign-extended to XLEN when XLEN > 32.
- Load-use detection: `HazardStall = ValidE & ResultSrcE & (RD_E != 0) & ValidD & (RD_E == rs1D | RD_E == rs2D) & !FlushE`.
  - rs2 is compared for every format. This is conservative by design.
- E register update on each rising `clk`, first matching rule wins:
  1. `FlushE`: load a bubble.
  2. `StallE`: hold all E outputs.
  3. `HazardStall` or `!ValidD`: load a bubble.
  4. Otherwise: load the decoded D values with `ValidE = 1`.
- Bubble contents: every control output 0, `ALUControlE = 000`, all data and index outputs 0, `ValidE = 0`.
- `BubbleCount` increments by 1 on each edge where rule 1 fires, or rule 3 fires because of `HazardStall`.
  - An invalid-D bubble does not count.
  - Saturates at 2^CNT_W − 1. No wrap.

## Timing
- Reset: all E outputs and `BubbleCount` are 0 immediately and asynchronously, independent of `clk`. `HazardStall` is therefore 0 while in reset.
- Reset asserted mid-operation discards the E contents and register file contents with no partial state. First capture happens on the first rising edge after `rst` deasserts.
- Latency: D inputs appear on E outputs 1 cycle later.
- `HazardStall` is combinational in the same cycle as the offending D instruction.
  - With upstream holding D, the stall lasts exactly 1 cycle: after the bubble, `ValidE = 0` and the hazard clears.
  - The instruction then enters E on the following edge.
- Writeback in the same cycle as a decode read of the same register: D sees `ResultW`, so there is no extra cycle.
- `StallE` together with `HazardStall`: E holds, `HazardStall` stays high and the counter does not increment.
- `FlushE` together with `StallE`: flush wins.
- Simultaneous `FlushE` and a load-use condition: `HazardStall = 0` and the bubble is counted once.

## Test plan
- **Reset values:** drive `rst = 0` mid-stream with valid instructions in flight → all E outputs 0 and `BubbleCount = 0` without waiting for a clock edge. After release, the register file reads 0 for x1–x31.
- **Basic decode:** preload x1 = 5, x2 = 7 via the W port, then `InstrD = 0x002081B3` (`add x3,x1,x2`) with `ValidD = 1` → next edge `RD1_E = 5`, `RD2_E = 7`, `RD_E = 3`, `RS1_E = 1`, `RS2_E = 2`, `RegWriteE = 1`, `ValidE = 1`, `PCE = PCD`.
- **Write-through:** `RegWriteW = 1`, `RDW = 1`, `ResultW = 0x1234` in the same cycle as `add x3,x1,x2` in D → `RD1_E = 0x1234`. `RDW = 0` with `ResultW = 0xFFFF` → x0 still reads 0.
- **Load-use:** `lw x5,0(x1)` (`0x0000A283`) in E, then `add x6,x5,x2` (`0x00228333`) in D → `HazardStall = 1` and the next E is a bubble with `BubbleCount = 1`. Holding D one more cycle → `HazardStall = 0` and the add enters E with `ValidE = 1`. Repeat with rd = x0 → no stall.
- **Stall/flush priority:** `StallE = 1` for 3 cycles → E outputs constant. `StallE = 1` and `FlushE = 1` together → bubble and the counter increments. `ValidD = 0` → bubble and the counter does not increment.
- **Saturation:** with `CNT_W = 2`, apply `FlushE` for 5 cycles → `BubbleCount` reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/decode_stage_hz.sv
// ID/EX stage: decode, write-through register file, load-use hazard
// detection and the E pipeline register with stall/flush/bubble control.
module decode_stage_hz #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int CNT_W = 16,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ValidD,
    input  logic [31:0]      InstrD,
    input  logic [XLEN-1:0]  PCD,
    input  logic [XLEN-1:0]  PCPlus4D,
    input  logic             StallE,
    input  logic             FlushE,
    input  logic             RegWriteW,
    input  logic [AW-1:0]    RDW,
    input  logic [XLEN-1:0]  ResultW,
    output logic             HazardStall,
    output logic             ValidE,
    output logic             RegWriteE,
    output logic             ALUSrcE,
    output logic             MemWriteE,
    output logic             ResultSrcE,
    output logic             BranchE,
    output logic [2:0]       ALUControlE,
    output logic [XLEN-1:0]  RD1_E,
    output logic [XLEN-1:0]  RD2_E,
    output logic [XLEN-1:0]  Imm_Ext_E,
    output logic [XLEN-1:0]  PCE,
    output logic [XLEN-1:0]  PCPlus4E,
    output logic [AW-1:0]    RS1_E,
    output logic [AW-1:0]    RS2_E,
    output logic [AW-1:0]    RD_E,
    output logic [CNT_W-1:0] BubbleCount
);

    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic            alu_src;
        logic            mem_write;
        logic            result_src;
        logic            branch;
        logic [2:0]      alu_ctl;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [AW-1:0]   rs1;
        logic [AW-1:0]   rs2;
        logic [AW-1:0]   rd;
    } ex_t;

    logic [XLEN-1:0]  rf_q [NREGS];
    ex_t              e_q, e_d, dec;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cnt_inc;

    logic [6:0]  op;
    logic [2:0]  f3;
    logic [1:0]  imm_src, alu_op;
    logic [31:0] imm32;
    logic [AW-1:0] rs1_d, rs2_d, rd_d;

    assign op    = InstrD[6:0];
    assign f3    = InstrD[14:12];
    assign rs1_d = InstrD[15+:AW];
    assign rs2_d = InstrD[20+:AW];
    assign rd_d  = InstrD[7+:AW];

    always_comb begin
        dec = '0;
        imm_src = 2'b00;
        alu_op = 2'b00;
        unique case (op)
            7'b0000011: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = 1'b1;
            end
            7'b0100011: begin
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
                imm_src       = 2'b01;
            end
            7'b0110011: begin
                dec.reg_write = 1'b1;
                alu_op        = 2'b10;
            end
            7'b1100011: begin
                dec.branch = 1'b1;
                imm_src    = 2'b10;
                alu_op     = 2'b01;
            end
            default: ;
        endcase
        unique case (alu_op)
            2'b00: dec.alu_ctl = 3'b000;
            2'b01: dec.alu_ctl = 3'b001;
            default: begin
                case (f3)
                    3'b000:  dec.alu_ctl = (op[5] & InstrD[30]) ? 3'b001 : 3'b000;
                    3'b010:  dec.alu_ctl = 3'b101;
                    3'b110:  dec.alu_ctl = 3'b011;
                    3'b111:  dec.alu_ctl = 3'b010;
                    default: dec.alu_ctl = 3'b000;
                endcase
            end
        endcase
        unique case (imm_src)
            2'b01:   imm32 = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            2'b10:   imm32 = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25],
                              InstrD[11:8], 1'b0};
            default: imm32 = {{20{InstrD[31]}}, InstrD[31:20]};
        endcase
        dec.imm   = XLEN'($signed(imm32));
        dec.valid = 1'b1;
        dec.pc    = PCD;
        dec.pc4   = PCPlus4D;
        dec.rs1   = rs1_d;
        dec.rs2   = rs2_d;
        dec.rd    = rd_d;
        // Write-through lets D see a same-cycle writeback without a stall
        dec.rd1 = (rs1_d == '0) ? '0 :
                  (RegWriteW && RDW == rs1_d) ? ResultW : rf_q[rs1_d];
        dec.rd2 = (rs2_d == '0) ? '0 :
                  (RegWriteW && RDW == rs2_d) ? ResultW : rf_q[rs2_d];
    end

    assign HazardStall = e_q.valid & e_q.result_src & (e_q.rd != '0) &
                         ValidD & ((e_q.rd == rs1_d) | (e_q.rd == rs2_d)) &
                         ~FlushE;

    always_comb begin
        e_d = e_q;
        cnt_inc = 1'b0;
        priority case (1'b1)
            FlushE: begin
                e_d = '0;
                cnt_inc = 1'b1;
            end
            StallE: e_d = e_q;
            HazardStall: begin
                e_d = '0;
                cnt_inc = 1'b1;
            end
            !ValidD: e_d = '0;
            default: e_d = dec;
        endcase
        cnt_d = (cnt_inc && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else if (RegWriteW && RDW != '0) begin
            rf_q[RDW] <= ResultW;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_q   <= '0;
            cnt_q <= '0;
        end else begin
            e_q   <= e_d;
            cnt_q <= cnt_d;
        end
    end

    assign ValidE      = e_q.valid;
    assign RegWriteE   = e_q.reg_write;
    assign ALUSrcE     = e_q.alu_src;
    assign MemWriteE   = e_q.mem_write;
    assign ResultSrcE  = e_q.result_src;
    assign BranchE     = e_q.branch;
    assign ALUControlE = e_q.alu_ctl;
    assign RD1_E       = e_q.rd1;
    assign RD2_E       = e_q.rd2;
    assign Imm_Ext_E   = e_q.imm;
    assign PCE         = e_q.pc;
    assign PCPlus4E    = e_q.pc4;
    assign RS1_E       = e_q.rs1;
    assign RS2_E       = e_q.rs2;
    assign RD_E        = e_q.rd;
    assign BubbleCount = cnt_q;

endmodule

// File: tb/tb_decode_stage_hz.sv
// Scoreboard bench for decode_stage_hz: expected E contents are queued
// as stimulus is driven and compared one cycle later.
module tb_decode_stage_hz;

    typedef struct packed {
        logic [5:0]  ctl;
        logic [2:0]  alu;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [4:0]  s1;
        logic [4:0]  s2;
        logic [4:0]  d;
        logic [15:0] cnt;
    } e_t;

    localparam logic [31:0] ADD   = 32'h002081B3;
    localparam logic [31:0] SUB   = 32'h402081B3;
    localparam logic [31:0] SW    = 32'hFE20AE23;
    localparam logic [31:0] BEQ   = 32'h00208463;
    localparam logic [31:0] ADDX0 = 32'h002001B3;
    localparam logic [31:0] LW5   = 32'h0000A283;
    localparam logic [31:0] ADD6  = 32'h00228333;
    localparam logic [31:0] LW0   = 32'h0000A003;
    localparam logic [31:0] ADD60 = 32'h00200333;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        ValidD, StallE, FlushE, FlushS, RegWriteW;
    logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
    logic [4:0]  RDW;

    logic        HazardStall, ValidE, RegWriteE, ALUSrcE, MemWriteE;
    logic        ResultSrcE, BranchE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
    logic [4:0]  RS1_E, RS2_E, RD_E;
    logic [15:0] BubbleCount;

    logic        s_hz, s_v, s_rw, s_as, s_mw, s_rs, s_br;
    logic [2:0]  s_alu;
    logic [31:0] s_rd1, s_rd2, s_imm, s_pc, s_pc4;
    logic [4:0]  s_s1, s_s2, s_d;
    logic [1:0]  s_cnt;

    decode_stage_hz #(.XLEN(32), .NREGS(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .ValidD(ValidD), .InstrD(InstrD),
        .PCD(PCD), .PCPlus4D(PCPlus4D), .StallE(StallE), .FlushE(FlushE),
        .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW),
        .HazardStall(HazardStall), .ValidE(ValidE), .RegWriteE(RegWriteE),
        .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
        .BranchE(BranchE), .ALUControlE(ALUControlE), .RD1_E(RD1_E),
        .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE),
        .PCPlus4E(PCPlus4E), .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E),
        .BubbleCount(BubbleCount)
    );

    decode_stage_hz #(.XLEN(32), .NREGS(32), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .ValidD(ValidD), .InstrD(InstrD),
        .PCD(PCD), .PCPlus4D(PCPlus4D), .StallE(StallE), .FlushE(FlushS),
        .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW),
        .HazardStall(s_hz), .ValidE(s_v), .RegWriteE(s_rw),
        .ALUSrcE(s_as), .MemWriteE(s_mw), .ResultSrcE(s_rs),
        .BranchE(s_br), .ALUControlE(s_alu), .RD1_E(s_rd1),
        .RD2_E(s_rd2), .Imm_Ext_E(s_imm), .PCE(s_pc),
        .PCPlus4E(s_pc4), .RS1_E(s_s1), .RS2_E(s_s2), .RD_E(s_d),
        .BubbleCount(s_cnt)
    );

    int   nchk = 0;
    int   nerr = 0;
    e_t   sb[$];
    int   sbc[$];
    e_t   got, e;
    e_t   ea, lws;

    function automatic e_t obs();
        return {ValidE, RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE,
                ALUControlE, RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E,
                RS1_E, RS2_E, RD_E, BubbleCount};
    endfunction

    function automatic e_t mk(input logic [5:0] ctl, input logic [2:0] alu,
                              input logic [31:0] rd1, input logic [31:0] rd2,
                              input logic [31:0] imm, input logic [31:0] pc,
                              input logic [4:0] s1, input logic [4:0] s2,
                              input logic [4:0] d, input logic [15:0] cnt);
        return {ctl, alu, rd1, rd2, imm, pc, pc + 32'd4, s1, s2, d, cnt};
    endfunction

    function automatic e_t bub(input logic [15:0] cnt);
        e_t b;
        b = '0;
        b.cnt = cnt;
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        got = obs();
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc);
        ValidD = 1'b1;
        InstrD = ins;
        PCD = pc;
        PCPlus4D = pc + 32'd4;
    endtask

    task automatic test_reset();
        logic [4:0] r;
        #1;
        nchk++;
        if (obs() !== '0 || HazardStall !== 1'b0) begin
            nerr++;
            $display("FAIL reset_init got=%h hz=%b exp=0", obs(), HazardStall);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        RegWriteW = 1'b1;
        for (int i = 1; i < 32; i++) begin
            RDW = 5'(i);
            ResultW = 32'(i * 3 + 1);
            tick();
        end
        RegWriteW = 1'b0;
        drive(ADD, 32'h40);
        tick();
        tick();
        #2 rst = 1'b0;
        #1;
        nchk++;
        if (obs() !== '0 || HazardStall !== 1'b0) begin
            nerr++;
            $display("FAIL reset_async got=%h hz=%b exp=0", obs(), HazardStall);
        end
        @(posedge clk);
        #1;
        nchk++;
        if (obs() !== '0) begin
            nerr++;
            $display("FAIL reset_hold got=%h exp=0", obs());
        end
        rst = 1'b1;
        for (int i = 1; i < 32; i++) begin
            r = 5'(i);
            drive({7'b0, r, r, 3'b0, r, 7'h33}, 32'(i * 4));
            sb.push_back(mk(6'b110000, 3'b000, 32'h0, 32'h0, 32'(i),
                            32'(i * 4), r, r, r, 16'd0));
            tick();
            e = sb.pop_front();
            nchk++;
            if (got !== e) begin
                nerr++;
                $display("FAIL rf_clear x%0d got=%h exp=%h", i, got, e);
            end
        end
    endtask

    task automatic test_basic();
        ValidD = 1'b0;
        RegWriteW = 1'b1;
        RDW = 5'd1;
        ResultW = 32'd5;
        tick();
        RDW = 5'd2;
        ResultW = 32'd7;
        tick();
        RegWriteW = 1'b0;
        sb.push_back(mk(6'b110000, 3'b000, 5, 7, 2, 32'h100, 1, 2, 3, 0));
        sb.push_back(mk(6'b110000, 3'b001, 5, 7, 32'h402, 32'h104, 1, 2, 3, 0));
        sb.push_back(mk(6'b101100, 3'b000, 5, 7, 32'hFFFFFFFC, 32'h108,
                        1, 2, 28, 0));
        sb.push_back(mk(6'b100001, 3'b001, 5, 7, 8, 32'h10C, 1, 2, 8, 0));
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: drive(ADD, 32'h100);
                1: drive(SUB, 32'h104);
                2: drive(SW, 32'h108);
                default: drive(BEQ, 32'h10C);
            endcase
            tick();
            e = sb.pop_front();
            nchk++;
            if (got !== e) begin
                nerr++;
                $display("FAIL basic_%0d got=%h exp=%h", k, got, e);
            end
        end
    endtask

    task automatic test_write_through();
        for (int k = 0; k < 3; k++) begin
            RegWriteW = (k < 2);
            RDW = (k == 0) ? 5'd1 : 5'd0;
            ResultW = (k == 0) ? 32'h1234 : 32'hFFFF;
            drive((k == 0) ? ADD : ADDX0, 32'(32'h200 + k * 4));
            if (k == 0)
                sb.push_back(mk(6'b110000, 0, 32'h1234, 7, 2, 32'h200, 1, 2, 3, 0));
            else
                sb.push_back(mk(6'b110000, 0, 0, 7, 2, 32'(32'h200 + k * 4),
                                0, 2, 3, 0));
            tick();
            e = sb.pop_front();
            nchk++;
            if (got !== e) begin
                nerr++;
                $display("FAIL wthru_%0d got=%h exp=%h", k, got, e);
            end
        end
        RegWriteW = 1'b0;
    endtask

    task automatic test_load_use();
        logic [31:0] ins [5];
        logic        hz [5];
        ins = '{LW5, ADD6, ADD6, LW0, ADD60};
        hz  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        sb.push_back(mk(6'b111010, 0, 32'h1234, 0, 0, 32'h300, 1, 0, 5, 0));
        sb.push_back(bub(16'd1));
        sb.push_back(mk(6'b110000, 0, 0, 7, 2, 32'h304, 5, 2, 6, 1));
        sb.push_back(mk(6'b111010, 0, 32'h1234, 0, 0, 32'h308, 1, 0, 0, 1));
        sb.push_back(mk(6'b110000, 0, 0, 7, 2, 32'h30C, 0, 2, 6, 1));
        for (int k = 0; k < 5; k++) begin
            drive(ins[k], (k < 2) ? 32'(32'h300 + k * 4) : 32'(32'h2FC + k * 4));
            #1;
            nchk++;
            if (HazardStall !== hz[k]) begin
                nerr++;
                $display("FAIL lu_hz_%0d got=%b exp=%b", k, HazardStall, hz[k]);
            end
            tick();
            e = sb.pop_front();
            nchk++;
            if (got !== e) begin
                nerr++;
                $display("FAIL lu_e_%0d got=%h exp=%h", k, got, e);
            end
        end
    endtask

    task automatic test_stall_flush();
        ea  = mk(6'b110000, 0, 0, 7, 2, 32'h30C, 0, 2, 6, 1);
        lws = mk(6'b111010, 0, 32'h1234, 0, 0, 32'h404, 1, 0, 5, 1);
        StallE = 1'b1;
        drive(ADD, 32'h400);
        for (int k = 0; k < 3; k++) begin
            sb.push_back(ea);
            tick();
            e = sb.pop_front();
            nchk++;
            if (got !== e) begin
                nerr++;
                $display("FAIL stall_hold_%0d got=%h exp=%h", k, got, e);
            end
        end
        StallE = 1'b0;
        drive(LW5, 32'h404);
        sb.push_back(lws);
        tick();
        e = sb.pop_front();
        nchk++;
        if (got !== e) begin
            nerr++;
            $display("FAIL stall_load got=%h exp=%h", got, e);
        end
        StallE = 1'b1;
        drive(ADD6, 32'h408);
        #1;
        nchk++;
        if (HazardStall !== 1'b1) begin
            nerr++;
            $display("FAIL stall_hz got=%b exp=1", HazardStall);
        end
        sb.push_back(lws);
        tick();
        e = sb.pop_front();
        nchk++;
        if (got !== e) begin
            nerr++;
            $display("FAIL stall_hz_hold got=%h exp=%h", got, e);
        end
        FlushE = 1'b1;
        #1;
        nchk++;
        if (HazardStall !== 1'b0) begin
            nerr++;
            $display("FAIL flush_mask_hz got=%b exp=0", HazardStall);
        end
        sb.push_back(bub(16'd2));
        tick();
        e = sb.pop_front();
        nchk++;
        if (got !== e) begin
            nerr++;
            $display("FAIL flush_stall got=%h exp=%h", got, e);
        end
        StallE = 1'b0;
        FlushE = 1'b0;
        ValidD = 1'b0;
        sb.push_back(bub(16'd2));
        tick();
        e = sb.pop_front();
        nchk++;
        if (got !== e) begin
            nerr++;
            $display("FAIL invalid_bubble got=%h exp=%h", got, e);
        end
    endtask

    task automatic test_saturation();
        int x;
        rst = 1'b0;
        #1;
        nchk++;
        if (s_cnt !== 2'd0) begin
            nerr++;
            $display("FAIL sat_reset got=%0d exp=0", s_cnt);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        ValidD = 1'b0;
        FlushS = 1'b1;
        for (int k = 0; k < 5; k++) begin
            sbc.push_back((k < 3) ? k + 1 : 3);
            tick();
            x = sbc.pop_front();
            nchk++;
            if (s_cnt !== 2'(x)) begin
                nerr++;
                $display("FAIL sat_%0d got=%0d exp=%0d", k, s_cnt, x);
            end
        end
        FlushS = 1'b0;
    endtask

    initial begin
        ValidD = 1'b0;
        StallE = 1'b0;
        FlushE = 1'b0;
        FlushS = 1'b0;
        RegWriteW = 1'b0;
        InstrD = '0;
        PCD = '0;
        PCPlus4D = '0;
        ResultW = '0;
        RDW = '0;
        test_reset();
        test_basic();
        test_write_through();
        test_load_use();
        test_stall_flush();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
